mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 33 +++
 rtl/mem_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: FSM states,
// busy codes and load/store length codes.
package mem_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_IF_RD  = 3'd1,
      ST_MEM_RD = 3'd2,
      ST_MEM_WR = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam logic [1:0] BUSY_IDLE = 2'b00;
   localparam logic [1:0] BUSY_IF   = 2'b01;
   localparam logic [1:0] BUSY_MEM  = 2'b10;

   localparam logic [1:0] LEN_1  = 2'b00;
   localparam logic [1:0] LEN_2  = 2'b01;
   localparam logic [1:0] LEN_4  = 2'b10;
   localparam logic [1:0] LEN_4X = 2'b11;

   localparam logic [1:0] LAST_WORD = 2'd3;

   // Index of the final byte of a transfer (byte count minus one).
   function automatic logic [1:0] last_idx(input logic [1:0] len);
      case (len)
         LEN_1:   return 2'd0;
         LEN_2:   return 2'd1;
         default: return LAST_WORD;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating instruction fetch and load/store;
// every output is a register fed from the next-state logic.
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        if_req_in,
   input  logic [31:0] if_addr_in,
   input  logic        branch_flag_in,
   input  logic        mem_req_in,
   input  logic        mem_we_in,
   input  logic [31:0] mem_addr_in,
   input  logic [1:0]  mem_len_in,
   input  logic [31:0] mem_wdata_in,
   input  logic [7:0]  ram_din_in,
   output logic [1:0]  busy_out,
   output logic        if_done_out,
   output logic [31:0] if_inst_out,
   output logic        mem_done_out,
   output logic [31:0] mem_rdata_out,
   output logic [31:0] ram_a_out,
   output logic [7:0]  ram_dout_out,
   output logic        ram_wr_out
);

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  last_q, last_d;
   logic [31:0] asm_q, asm_d;
   logic [31:0] wdata_q, wdata_d;
   logic        primed_q, primed_d;

   logic [1:0]  busy_d;
   logic        if_done_d, mem_done_d, ram_wr_d;
   logic [31:0] if_inst_d, mem_rdata_d, ram_a_d;
   logic [7:0]  ram_dout_d;

   logic [1:0]  cnt_inc;
   logic [2:0]  issue_idx;
   logic        last_smp;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      asm_d       = asm_q;
      wdata_d     = wdata_q;
      primed_d    = primed_q;
      busy_d      = busy_out;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
      if_inst_d   = 32'd0;
      mem_rdata_d = 32'd0;
      ram_a_d     = ram_a_out;
      ram_wr_d    = 1'b0;
      ram_dout_d  = 8'd0;

      cnt_inc   = cnt_q + 2'd1;
      // Reads lag the address by one cycle: primed_q marks that ram_din_in
      // now carries byte cnt_q, and issue_idx is the next address to present.
      issue_idx = primed_q ? ({1'b0, cnt_q} + 3'd2) : 3'd1;
      last_smp  = primed_q && (cnt_q == last_q);

      case (state_q)
         ST_IDLE: begin
            busy_d   = BUSY_IDLE;
            cnt_d    = 2'd0;
            primed_d = 1'b0;
            asm_d    = 32'd0;
            if (mem_req_in) begin
               ram_a_d = mem_addr_in;
               last_d  = last_idx(mem_len_in);
               wdata_d = mem_wdata_in;
               busy_d  = BUSY_MEM;
               if (mem_we_in) begin
                  state_d    = ST_MEM_WR;
                  ram_wr_d   = 1'b1;
                  ram_dout_d = mem_wdata_in[7:0];
               end else begin
                  state_d = ST_MEM_RD;
               end
            end else if (if_req_in) begin
               ram_a_d = if_addr_in;
               last_d  = LAST_WORD;
               busy_d  = BUSY_IF;
               state_d = ST_IF_RD;
            end
         end

         ST_IF_RD, ST_MEM_RD: begin
            if (state_q == ST_IF_RD && branch_flag_in) begin
               state_d = ST_IDLE;
               busy_d  = BUSY_IDLE;
            end else begin
               if (issue_idx <= {1'b0, last_q})
                  ram_a_d = ram_a_out + 32'd1;
               primed_d = 1'b1;
               if (primed_q) begin
                  asm_d[{cnt_q, 3'b000} +: 8] = ram_din_in;
                  if (last_smp) begin
                     state_d = ST_DONE;
                     if (state_q == ST_IF_RD) begin
                        if_done_d = 1'b1;
                        if_inst_d = asm_d;
                     end else begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = asm_d;
                     end
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end
            end
         end

         ST_MEM_WR: begin
            if (cnt_q == last_q) begin
               state_d    = ST_DONE;
               mem_done_d = 1'b1;
            end else begin
               cnt_d      = cnt_inc;
               ram_a_d    = ram_a_out + 32'd1;
               ram_wr_d   = 1'b1;
               ram_dout_d = wdata_q[{cnt_inc, 3'b000} +: 8];
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = BUSY_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = BUSY_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 2'd0;
         last_q        <= 2'd0;
         asm_q         <= 32'd0;
         wdata_q       <= 32'd0;
         primed_q      <= 1'b0;
         busy_out      <= BUSY_IDLE;
         if_done_out   <= 1'b0;
         if_inst_out   <= 32'd0;
         mem_done_out  <= 1'b0;
         mem_rdata_out <= 32'd0;
         ram_a_out     <= 32'd0;
         ram_dout_out  <= 8'd0;
         ram_wr_out    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         last_q        <= last_d;
         asm_q         <= asm_d;
         wdata_q       <= wdata_d;
         primed_q      <= primed_d;
         busy_out      <= busy_d;
         if_done_out   <= if_done_d;
         if_inst_out   <= if_inst_d;
         mem_done_out  <= mem_done_d;
         mem_rdata_out <= mem_rdata_d;
         ram_a_out     <= ram_a_d;
         ram_dout_out  <= ram_dout_d;
         ram_wr_out    <= ram_wr_d;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a transaction-level model fills per-cycle
// expectation tables that one negedge process compares against the DUT.
module tb_mem_ctrl;

   localparam int K_IF = 0;
   localparam int K_LD = 1;
   localparam int K_ST = 2;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        if_req_in;
   logic [31:0] if_addr_in;
   logic        branch_flag_in;
   logic        mem_req_in;
   logic        mem_we_in;
   logic [31:0] mem_addr_in;
   logic [1:0]  mem_len_in;
   logic [31:0] mem_wdata_in;
   logic [7:0]  ram_din_in = 8'd0;
   logic [1:0]  busy_out;
   logic        if_done_out;
   logic [31:0] if_inst_out;
   logic        mem_done_out;
   logic [31:0] mem_rdata_out;
   logic [31:0] ram_a_out;
   logic [7:0]  ram_dout_out;
   logic        ram_wr_out;

   mem_ctrl dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .if_req_in      (if_req_in),
      .if_addr_in     (if_addr_in),
      .branch_flag_in (branch_flag_in),
      .mem_req_in     (mem_req_in),
      .mem_we_in      (mem_we_in),
      .mem_addr_in    (mem_addr_in),
      .mem_len_in     (mem_len_in),
      .mem_wdata_in   (mem_wdata_in),
      .ram_din_in     (ram_din_in),
      .busy_out       (busy_out),
      .if_done_out    (if_done_out),
      .if_inst_out    (if_inst_out),
      .mem_done_out   (mem_done_out),
      .mem_rdata_out  (mem_rdata_out),
      .ram_a_out      (ram_a_out),
      .ram_dout_out   (ram_dout_out),
      .ram_wr_out     (ram_wr_out)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   // RAM contents and the bench-side RAM
   logic [7:0] ram [bit [31:0]];

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      case (a)
         32'h0000_1000: return 8'h13;
         32'h0000_1001: return 8'h05;
         32'h0000_2000: return 8'h93;
         32'h0000_2002: return 8'h10;
         32'h0000_3000: return 8'hAB;
         32'h0000_3001: return 8'hCD;
         32'h0000_3002: return 8'hEF;
         32'h0000_3003: return 8'h01;
         32'h0000_0031: return 8'h7F;
         32'h0000_0032: return 8'h80;
         32'h0000_0045: return 8'hF0;
         32'hFFFF_FFFE: return 8'h11;
         32'hFFFF_FFFF: return 8'h22;
         32'h0000_0000: return 8'h33;
         32'h0000_0001: return 8'h44;
         default:       return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      if (ram.exists(a)) return ram[a];
      return init_byte(a);
   endfunction

   always @(posedge clk_in) begin
      ram_din_in <= mem_byte(ram_a_out);
      if (ram_wr_out) ram[ram_a_out] = ram_dout_out;
   end

   // Expectation tables, keyed by cycle number
   logic [1:0]  e_busy  [int];
   logic [31:0] e_a     [int];
   logic [7:0]  e_dout  [int];
   logic [31:0] e_inst  [int];
   bit          e_mdone [int];
   logic [31:0] e_rdata [int];
   logic [31:0] lit_inst  [int];
   logic [31:0] lit_rdata [int];
   logic [1:0]  lit_busy  [int];
   logic [31:0] lit_wa    [int];
   logic [7:0]  lit_wd    [int];

   // Transaction accepted in cycle t; abort = first cycle it no longer exists (0 = never).
   function automatic void plan(input int t, input int kind, input logic [31:0] addr,
                                input int n, input logic [31:0] wd, input int abort);
      int          done_c;
      int          k;
      logic [31:0] word;
      done_c = (kind == K_ST) ? t + n + 1 : t + n + 2;
      for (int c = t + 1; c <= done_c; c++) begin
         if (abort != 0 && c >= abort) break;
         k = c - t - 1;
         e_busy[c] = (kind == K_IF) ? 2'b01 : 2'b10;
         e_a[c]    = (k < n) ? addr + 32'(k) : addr + 32'(n - 1);
         if (kind == K_ST && k < n) e_dout[c] = wd[8*k +: 8];
      end
      if (abort == 0 || abort > done_c) begin
         word = 32'd0;
         if (kind != K_ST)
            for (int b = 0; b < n; b++) word[8*b +: 8] = mem_byte(addr + 32'(b));
         if (kind == K_IF) e_inst[done_c] = word;
         else begin
            e_mdone[done_c] = 1'b1;
            if (kind == K_LD) e_rdata[done_c] = word;
         end
      end
   endfunction

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endfunction

   always @(negedge clk_in) begin
      if (!rst_in) begin
         chk("rst_busy", 32'(busy_out), 32'd0);
         chk("rst_if_done", 32'(if_done_out), 32'd0);
         chk("rst_if_inst", if_inst_out, 32'd0);
         chk("rst_mem_done", 32'(mem_done_out), 32'd0);
         chk("rst_rdata", mem_rdata_out, 32'd0);
         chk("rst_ram_a", ram_a_out, 32'd0);
         chk("rst_ram_dout", 32'(ram_dout_out), 32'd0);
         chk("rst_ram_wr", 32'(ram_wr_out), 32'd0);
      end else begin
         chk("busy", 32'(busy_out), e_busy.exists(cyc) ? 32'(e_busy[cyc]) : 32'd0);
         chk("if_done", 32'(if_done_out), 32'(e_inst.exists(cyc)));
         if (e_inst.exists(cyc)) chk("if_inst", if_inst_out, e_inst[cyc]);
         chk("mem_done", 32'(mem_done_out), 32'(e_mdone.exists(cyc)));
         if (e_rdata.exists(cyc)) chk("mem_rdata", mem_rdata_out, e_rdata[cyc]);
         chk("ram_wr", 32'(ram_wr_out), 32'(e_dout.exists(cyc)));
         chk("ram_dout", 32'(ram_dout_out), e_dout.exists(cyc) ? 32'(e_dout[cyc]) : 32'd0);
         if (e_a.exists(cyc)) chk("ram_a", ram_a_out, e_a[cyc]);
         if (lit_inst.exists(cyc)) begin
            chk("lit_if_done", 32'(if_done_out), 32'd1);
            chk("lit_if_inst", if_inst_out, lit_inst[cyc]);
         end
         if (lit_rdata.exists(cyc)) begin
            chk("lit_mem_done", 32'(mem_done_out), 32'd1);
            chk("lit_mem_rdata", mem_rdata_out, lit_rdata[cyc]);
         end
         if (lit_busy.exists(cyc)) chk("lit_busy", 32'(busy_out), 32'(lit_busy[cyc]));
         if (lit_wa.exists(cyc)) begin
            chk("lit_wr", 32'(ram_wr_out), 32'd1);
            chk("lit_wa", ram_a_out, lit_wa[cyc]);
            chk("lit_wd", 32'(ram_dout_out), 32'(lit_wd[cyc]));
         end
      end
   end

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   initial begin
      rst_in = 1'b0;
      if_req_in = 1'b0; if_addr_in = 32'd0; branch_flag_in = 1'b0;
      mem_req_in = 1'b0; mem_we_in = 1'b0; mem_addr_in = 32'd0;
      mem_len_in = 2'b00; mem_wdata_in = 32'd0;
      goto(2);
      rst_in = 1'b1;

      // Fetch at 0x1000: 13 05 00 00 -> 0x00000513 in T+6
      goto(4);
      if_req_in = 1'b1; if_addr_in = 32'h1000;
      plan(4, K_IF, 32'h1000, 4, 32'd0, 0);
      lit_inst[10] = 32'h0000_0513;
      for (int c = 5; c <= 10; c++) lit_busy[c] = 2'b01;
      lit_busy[11] = 2'b00;
      goto(10);
      if_req_in = 1'b0;

      // Store wins over a simultaneous fetch; fetch is accepted afterwards
      goto(12);
      mem_req_in = 1'b1; mem_we_in = 1'b1; mem_addr_in = 32'h20;
      mem_len_in = 2'b10; mem_wdata_in = 32'hAABB_CCDD;
      if_req_in = 1'b1; if_addr_in = 32'h2000;
      plan(12, K_ST, 32'h20, 4, 32'hAABB_CCDD, 0);
      plan(18, K_IF, 32'h2000, 4, 32'd0, 0);
      lit_wa[13] = 32'h20; lit_wd[13] = 8'hDD;
      lit_wa[14] = 32'h21; lit_wd[14] = 8'hCC;
      lit_wa[15] = 32'h22; lit_wd[15] = 8'hBB;
      lit_wa[16] = 32'h23; lit_wd[16] = 8'hAA;
      lit_inst[24] = 32'h0010_0093;
      goto(17);
      mem_req_in = 1'b0; mem_we_in = 1'b0;
      goto(24);
      if_req_in = 1'b0;

      // Halfword load at odd address; branch and a stray fetch request are ignored
      goto(26);
      mem_req_in = 1'b1; mem_addr_in = 32'h31; mem_len_in = 2'b01;
      plan(26, K_LD, 32'h31, 2, 32'd0, 0);
      lit_rdata[30] = 32'h0000_807F;
      goto(27);
      branch_flag_in = 1'b1; if_req_in = 1'b1; if_addr_in = 32'h1000;
      goto(29);
      branch_flag_in = 1'b0; if_req_in = 1'b0;
      goto(30);
      mem_req_in = 1'b0;

      // Fetch flushed by branch in T+3, then a new fetch completes
      goto(32);
      if_req_in = 1'b1; if_addr_in = 32'h3000;
      plan(32, K_IF, 32'h3000, 4, 32'd0, 36);
      lit_busy[36] = 2'b00;
      goto(35);
      branch_flag_in = 1'b1; if_req_in = 1'b0;
      goto(36);
      branch_flag_in = 1'b0;
      goto(37);
      if_req_in = 1'b1; if_addr_in = 32'h2000;
      plan(37, K_IF, 32'h2000, 4, 32'd0, 0);
      lit_inst[43] = 32'h0010_0093;
      goto(43);
      if_req_in = 1'b0;

      // Byte load, zero-extended
      goto(45);
      mem_req_in = 1'b1; mem_addr_in = 32'h45; mem_len_in = 2'b00;
      plan(45, K_LD, 32'h45, 1, 32'd0, 0);
      lit_rdata[48] = 32'h0000_00F0;
      goto(48);
      mem_req_in = 1'b0;

      // len 11 word load wrapping past 0xFFFFFFFF
      goto(50);
      mem_req_in = 1'b1; mem_addr_in = 32'hFFFF_FFFE; mem_len_in = 2'b11;
      plan(50, K_LD, 32'hFFFF_FFFE, 4, 32'd0, 0);
      lit_rdata[56] = 32'h4433_2211;
      goto(56);
      mem_req_in = 1'b0;

      // Halfword store, then word read-back of the same location
      goto(58);
      mem_req_in = 1'b1; mem_we_in = 1'b1; mem_addr_in = 32'h40;
      mem_len_in = 2'b01; mem_wdata_in = 32'h1234_BEEF;
      plan(58, K_ST, 32'h40, 2, 32'h1234_BEEF, 0);
      lit_wa[59] = 32'h40; lit_wd[59] = 8'hEF;
      lit_wa[60] = 32'h41; lit_wd[60] = 8'hBE;
      goto(61);
      mem_req_in = 1'b0; mem_we_in = 1'b0;
      goto(63);
      mem_req_in = 1'b1; mem_addr_in = 32'h40; mem_len_in = 2'b10;
      plan(63, K_LD, 32'h40, 4, 32'd0, 0);
      lit_rdata[69] = 32'h0000_BEEF;
      goto(69);
      mem_req_in = 1'b0;

      // Reset in T+2 of a store aborts it; a fetch is then served normally
      goto(72);
      mem_req_in = 1'b1; mem_we_in = 1'b1; mem_addr_in = 32'h80;
      mem_len_in = 2'b10; mem_wdata_in = 32'h0102_0304;
      plan(72, K_ST, 32'h80, 4, 32'h0102_0304, 74);
      goto(74);
      rst_in = 1'b0; mem_req_in = 1'b0; mem_we_in = 1'b0;
      goto(76);
      rst_in = 1'b1;
      goto(77);
      if_req_in = 1'b1; if_addr_in = 32'h1000;
      plan(77, K_IF, 32'h1000, 4, 32'd0, 0);
      lit_inst[83] = 32'h0000_0513;
      goto(83);
      if_req_in = 1'b0;

      goto(88);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
